// File: rtl/systolic_feeder.sv
// rtl/systolic_feeder.sv - skewing operand sequencer for the NxN systolic multiply array
module systolic_feeder #(
   parameter int N     = 16,
   parameter int DW    = 16,
   parameter int KW    = 16,
   parameter int DRAIN = 3*(N-1)+1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [KW-1:0]   k_len,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*DW-1:0] in_a,
   input  logic [N*DW-1:0] in_b,
   output logic [N*DW-1:0] out_a,
   output logic [N*DW-1:0] out_b,
   output logic            busy,
   output logic            done
);

   localparam int CW = $clog2(DRAIN+1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_t;

   state_t        r_state;
   logic [KW-1:0] r_k_len;
   logic [KW-1:0] r_beat_cnt;
   logic [CW-1:0] r_drain_cnt;
   logic          w_accept;

   assign w_accept = (r_state == S_LOAD) && in_valid && in_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_k_len     <= '0;
         r_beat_cnt  <= '0;
         r_drain_cnt <= '0;
         in_ready    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && (k_len != '0)) begin
                  r_k_len    <= k_len;
                  r_beat_cnt <= '0;
                  in_ready   <= 1'b1;
                  busy       <= 1'b1;
                  r_state    <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_beat_cnt <= r_beat_cnt + KW'(1);
                  if (r_beat_cnt == r_k_len - KW'(1)) begin
                     in_ready    <= 1'b0;
                     r_drain_cnt <= CW'(DRAIN-1);
                     r_state     <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (r_drain_cnt == '0) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_drain_cnt <= r_drain_cnt - CW'(1);
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Lane g is a chain of g+1 registers; idle cycles shift zeros in.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [DW-1:0] r_sa [0:g];
      logic [DW-1:0] r_sb [0:g];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            for (int s = 0; s <= g; s++) begin
               r_sa[s] <= '0;
               r_sb[s] <= '0;
            end
         end else begin
            r_sa[0] <= w_accept ? in_a[DW*g +: DW] : '0;
            r_sb[0] <= w_accept ? in_b[DW*g +: DW] : '0;
            for (int s = 1; s <= g; s++) begin
               r_sa[s] <= r_sa[s-1];
               r_sb[s] <= r_sb[s-1];
            end
         end
      end

      assign out_a[DW*g +: DW] = r_sa[g];
      assign out_b[DW*g +: DW] = r_sb[g];
   end

endmodule
